// File: rtl/status_flag_unit.sv
// -----------------------------------------------------------------------------
// status_flag_unit
// Registered ALU status unit. Latches {C, V, N, Z} from the ALU result, keeps
// a sticky overflow bit, saves/restores the status on a small LIFO for
// interrupt entry/exit, and evaluates a 4-bit branch condition against the
// latched flags.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   alu_value    in   ALU result [WIDTH-1:0]
//   alu_carry    in   ALU carry/borrow out
//   alu_overflow in   ALU signed overflow
//   flag_we      in   latch new flags from the ALU inputs
//   push         in   save current status onto the stack
//   pop          in   restore status from the stack top
//   sticky_clr   in   clear the sticky overflow
//   cond         in   branch condition select [3:0]
//   status       out  {C, V, N, Z}
//   sticky_v     out  overflow seen since last clear
//   cond_true    out  cond satisfied by current status (combinational)
//   depth        out  stack occupancy
//   stack_full   out  depth == DEPTH
//   stack_empty  out  depth == 0
//   err          out  one-cycle pulse after an illegal stack operation
// -----------------------------------------------------------------------------
module status_flag_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           alu_value,
  input  logic                       alu_carry,
  input  logic                       alu_overflow,
  input  logic                       flag_we,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       sticky_clr,
  input  logic [3:0]                 cond,
  output logic [3:0]                 status,
  output logic                       sticky_v,
  output logic                       cond_true,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       err
);

  localparam int DW = $clog2(DEPTH + 1);
  // A single-entry stack still needs a one-bit index.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]    status_r;
  logic          sticky_r;
  logic [DW-1:0] depth_r;
  logic          err_r;
  logic [3:0]    stack_r [DEPTH];

  logic [3:0]    status_nxt_s;
  logic          sticky_nxt_s;
  logic [DW-1:0] depth_nxt_s;
  logic          err_nxt_s;
  logic          full_s;
  logic          empty_s;
  logic          push_ok_s;
  logic          pop_ok_s;
  logic [IW-1:0] push_idx_s;
  logic [IW-1:0] pop_idx_s;
  logic [3:0]    alu_flags_s;
  logic          cond_s;

  assign full_s     = (depth_r == DW'(DEPTH));
  assign empty_s    = (depth_r == {DW{1'b0}});
  assign push_idx_s = IW'(depth_r);
  assign pop_idx_s  = IW'(depth_r - DW'(1));

  // Operation decode and next-state selection for status, sticky, depth, err.
  always_comb begin
    alu_flags_s  = {alu_carry, alu_overflow, alu_value[WIDTH-1],
                    (alu_value == {WIDTH{1'b0}})};
    push_ok_s    = push & ~pop & ~full_s;
    pop_ok_s     = pop & ~push & ~empty_s;
    // push+pop together is never legal; otherwise overflow/underflow is.
    err_nxt_s    = (push & pop) | (push & ~pop & full_s) | (pop & ~push & empty_s);

    status_nxt_s = status_r;
    if (pop_ok_s) begin
      status_nxt_s = stack_r[pop_idx_s];
    end else if (flag_we) begin
      status_nxt_s = alu_flags_s;
    end else begin
      status_nxt_s = status_r;
    end

    depth_nxt_s = depth_r;
    if (push_ok_s) begin
      depth_nxt_s = depth_r + DW'(1);
    end else if (pop_ok_s) begin
      depth_nxt_s = depth_r - DW'(1);
    end else begin
      depth_nxt_s = depth_r;
    end

    // Setting wins over clearing so an overflow is never lost.
    sticky_nxt_s = sticky_r;
    if (flag_we & alu_overflow) begin
      sticky_nxt_s = 1'b1;
    end else if (sticky_clr) begin
      sticky_nxt_s = 1'b0;
    end else begin
      sticky_nxt_s = sticky_r;
    end
  end

  // Status, sticky, occupancy and error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_r <= 4'b0000;
      sticky_r <= 1'b0;
      depth_r  <= {DW{1'b0}};
      err_r    <= 1'b0;
    end else begin
      status_r <= status_nxt_s;
      sticky_r <= sticky_nxt_s;
      depth_r  <= depth_nxt_s;
      err_r    <= err_nxt_s;
    end
  end

  // Stack storage; contents are don't-care after reset, so no reset here.
  // The pre-edge status is stored, so push+flag_we saves the old flags.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      stack_r[push_idx_s] <= status_r;
    end
  end

  // Branch condition evaluation from the latched flags.
  always_comb begin
    cond_s = 1'b0;
    case (cond)
      4'd0:    cond_s = 1'b1;
      4'd1:    cond_s = status_r[0];
      4'd2:    cond_s = ~status_r[0];
      4'd3:    cond_s = status_r[1];
      4'd4:    cond_s = ~status_r[1];
      4'd5:    cond_s = status_r[2];
      4'd6:    cond_s = ~status_r[2];
      4'd7:    cond_s = status_r[3];
      4'd8:    cond_s = ~status_r[3];
      4'd9:    cond_s = status_r[3] & ~status_r[0];
      4'd10:   cond_s = ~status_r[3] | status_r[0];
      4'd11:   cond_s = (status_r[1] == status_r[2]);
      4'd12:   cond_s = (status_r[1] != status_r[2]);
      4'd13:   cond_s = ~status_r[0] & (status_r[1] == status_r[2]);
      4'd14:   cond_s = status_r[0] | (status_r[1] != status_r[2]);
      4'd15:   cond_s = 1'b0;
      default: cond_s = 1'b0;
    endcase
  end

  assign status      = status_r;
  assign sticky_v    = sticky_r;
  assign depth       = depth_r;
  assign stack_full  = full_s;
  assign stack_empty = empty_s;
  assign err         = err_r;
  assign cond_true   = cond_s;

endmodule
